// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with LATENCY wait states.
// Define DMEM_MISALIGN_ERR_EN to flag req_addr[1:0] != 0 through rsp_err.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          mis_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH];
    logic          accept, enter, mis;
    logic          unused_addr;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis = |req_addr[1:0];
`else
    assign mis = 1'b0;
`endif

    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        enter   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter   = 1'b1;
                    state_d = RESP;
                    rdata_d = (we_q || mis_q) ? 32'd0 : mem_q[idx_q];
                    err_d   = mis_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
                mis_q   <= mis;
            end
        end
    end

    // Array is deliberately not reset; writes happen only on RESP entry.
    always_ff @(posedge clk) begin
        if (enter && we_q && !mis_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (LATENCY=2 main, LATENCY=0 aux).
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_be0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] er, input logic ee);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input int hold);
        int n;
        exp_t e;
        logic [31:0] r0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_rsp_bound"}, 32'(n < 50), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(LAT + 1));
        e.rdata = 32'hxxxxxxxx;
        e.err   = 1'bx;
        if (sb.size() > 0) e = sb.pop_front();
        r0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, r0);
            chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0;
        req_wdata0 = '0; req_be0 = '0; rsp_ready0 = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // T1
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        collect("t1_st", 0);
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
        collect("t1_ld", 0);

        // T2
        issue(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'd0, 1'b0);
        collect("t2_st", 0);
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADABEF, 1'b0);
        collect("t2_ld", 0);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
        collect("t2_be0", 0);
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADABEF, 1'b0);
        collect("t2_ld2", 0);

        // T3: response held, competing request waits for the handshake
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADABEF, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        collect("t3_hold", 5);
        @(posedge clk);
        #1;
        chk("t3_second_taken", 32'(req_ready), 32'd0);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        begin
            exp_t e;
            e.rdata = 32'hDEADABEF;
            e.err   = 1'b0;
            sb.push_back(e);
        end
        collect("t3_second", 0);

        // T4: wrap, plus zero-latency instance
        issue(1'b1, 32'h400, 32'h12345678, 4'hF, 32'd0, 1'b0);
        collect("t4_st", 0);
        issue(1'b0, 32'h0, 32'd0, 4'h0, 32'h12345678, 1'b0);
        collect("t4_wrap", 0);
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8;
        req_wdata0 = 32'h0BADF00D; req_be0 = 4'hF;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        chk("t4_l0_wait", 32'(rsp_valid0), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_l0_valid", 32'(rsp_valid0), 32'd1);
        chk("t4_l0_rdata", rsp_rdata0, 32'd0);
        rsp_ready0 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready0 = 1'b0;
        chk("t4_l0_done", 32'(rsp_valid0), 32'd0);

        // T5: reset in WAIT drops the store
        issue(1'b1, 32'h20, 32'h11112222, 4'hF, 32'd0, 1'b0);
        collect("t5_pre", 0);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_rdata", rsp_rdata, 32'd0);
        chk("t5_rst_err", 32'(rsp_err), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_post_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h20, 32'd0, 4'h0, 32'h11112222, 1'b0);
        collect("t5_ld", 0);

        // T6: misaligned store
`ifdef DMEM_MISALIGN_ERR_EN
        issue(1'b1, 32'h12, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b1);
        collect("t6_st", 0);
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADABEF, 1'b0);
        collect("t6_ld", 0);
`else
        issue(1'b1, 32'h12, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
        collect("t6_st", 0);
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);
        collect("t6_ld", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
